// File: rtl/hc_pkg.sv
// Shared definitions for the current-sense front end: default ADC width,
// CAL/RUN state encoding and the offset-binary to two's-complement conversion.
package hc_pkg;

  localparam int ADC_W = 14;

  localparam logic [0:0] ST_CAL = 1'b0;
  localparam logic [0:0] ST_RUN = 1'b1;

  // Inverting the MSB of a w-bit offset-binary code gives its two's-complement
  // value; the result is sign-extended from bit w-1 to 32 bits.
  function automatic logic signed [31:0] ob_to_signed(input logic [31:0] raw, input int w);
    logic [31:0] t;
    t        = raw;
    t[w-1]   = ~t[w-1];
    return $signed(t << (32 - w)) >>> (32 - w);
  endfunction

endpackage

// File: rtl/sample_avg.sv
// Block averager over 2^LOG2 valid samples: signed running sum, sample count,
// and a one-cycle done pulse when a new average is latched.
module sample_avg #(
  parameter int W    = 14,
  parameter int LOG2 = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                valid,
  input  logic signed [W-1:0] sample,
  output logic signed [W-1:0] avg,
  output logic                done,
  output logic                last
);

  localparam int AW = W + LOG2;
  localparam logic [LOG2-1:0] CNT_MAX = '1;

  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] acc_next;
  logic [LOG2-1:0]      cnt;

  // Sum width grows by LOG2 bits, so a full window of extreme samples fits.
  assign acc_next = acc + AW'(sample);
  assign last     = valid && (cnt == CNT_MAX);

  // NOTE: reset is synchronous (sampled on the clock edge) and all state
  // updates use non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc  <= '0;
      cnt  <= '0;
      done <= 1'b0;
      avg  <= '0;
    end else if (clear) begin
      acc  <= '0;
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (valid) begin
        if (last) begin
          avg  <= W'(acc_next >>> LOG2);
          acc  <= '0;
          cnt  <= '0;
          done <= 1'b1;
        end else begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/current_sense.sv
// Current-sense front end: window-averages ADC samples, removes offset, scales
// and clamps. Define CURRENT_SENSE_OFFSET_CAL_EN to self-calibrate the offset.
module current_sense #(
  parameter int                 ADC_W    = hc_pkg::ADC_W,
  parameter int                 AVG_LOG2 = 4,
  parameter int                 CAL_LOG2 = 6,
  parameter logic signed [31:0] GAIN     = 32'sd3,
  parameter logic signed [31:0] I_MAX    = 32'sd10000
) (
  input  logic                i_clock,
  input  logic                i_reset_n,
  input  logic [ADC_W-1:0]    i_adc_data,
  input  logic                i_adc_valid,
  input  logic [ADC_W-1:0]    i_offset,
  output logic signed [31:0]  o_current,
  output logic                o_valid,
  output logic                o_cal_done
);

  localparam logic signed [63:0] LIM = 64'(I_MAX);

  logic [0:0]               state;
  logic signed [ADC_W-1:0]  sample;
  logic signed [ADC_W-1:0]  avg_val;
  logic signed [ADC_W-1:0]  offset_q;
  logic                     avg_done;
  logic                     avg_last;
  logic signed [63:0]       diff;
  logic signed [63:0]       prod;
  logic signed [31:0]       cur_next;

  assign sample = ADC_W'(hc_pkg::ob_to_signed(32'(i_adc_data), ADC_W));

  sample_avg #(.W(ADC_W), .LOG2(AVG_LOG2)) u_avg (
    .clk    (i_clock),
    .rst_n  (i_reset_n),
    .clear  (state == hc_pkg::ST_CAL),
    .valid  (i_adc_valid),
    .sample (sample),
    .avg    (avg_val),
    .done   (avg_done),
    .last   (avg_last)
  );

`ifdef CURRENT_SENSE_OFFSET_CAL_EN
  logic signed [ADC_W-1:0] cal_avg;
  logic                    cal_done;
  logic                    cal_last;

  sample_avg #(.W(ADC_W), .LOG2(CAL_LOG2)) u_cal (
    .clk    (i_clock),
    .rst_n  (i_reset_n),
    .clear  (state == hc_pkg::ST_RUN),
    .valid  (i_adc_valid),
    .sample (sample),
    .avg    (cal_avg),
    .done   (cal_done),
    .last   (cal_last)
  );

  // RUN is entered on the edge that accepts the last calibration sample; the
  // offset lands one edge later, well before the first run window can finish.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      state    <= hc_pkg::ST_CAL;
      offset_q <= '0;
    end else begin
      if (state == hc_pkg::ST_CAL && cal_last) state <= hc_pkg::ST_RUN;
      if (cal_done) offset_q <= cal_avg;
    end
  end
`else
  // Manual offset is captured alongside the window's last sample.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      state    <= hc_pkg::ST_RUN;
      offset_q <= '0;
    end else if (avg_last) begin
      offset_q <= ADC_W'(hc_pkg::ob_to_signed(32'(i_offset), ADC_W));
    end
  end
`endif

  // NOTE: every path assigns cur_next, so no latch is inferred here.
  always_comb begin
    diff = 64'(avg_val) - 64'(offset_q);
    prod = diff * 64'(GAIN);
    if (prod > LIM)       cur_next = I_MAX;
    else if (prod < -LIM) cur_next = -I_MAX;
    else                  cur_next = prod[31:0];
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      o_current <= '0;
      o_valid   <= 1'b0;
    end else begin
      o_valid <= avg_done;
      if (avg_done) o_current <= cur_next;
    end
  end

  assign o_cal_done = (state == hc_pkg::ST_RUN);

endmodule
